uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_if.sv | 24 ++
 rtl/uart_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Holds the one-hot FSM state encodings, default frame parameters and the
// helper that sizes the oversample tick counter.
package uart_pkg;

  // Default frame shape: 8 data bits, one stop bit (16 oversample ticks).
  localparam int UART_NB_DATA = 8;
  localparam int UART_SB_TICK = 16;

  // Oversample ticks per start/data/parity bit.
  localparam int UART_OS_TICKS = 16;

  // One-hot state encodings. Keep these as plain constants because older
  // tools in the receiver flow consume them too.
  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_START  = 5'b00010;
  localparam logic [4:0] ST_DATA   = 5'b00100;
  localparam logic [4:0] ST_PARITY = 5'b01000;
  localparam logic [4:0] ST_STOP   = 5'b10000;

  // The tick counter must hold both 0..15 and 0..SB_TICK-1 without wrapping.
  function automatic int tick_cnt_width(input int sb_tick);
    return ($clog2(sb_tick) > 4) ? $clog2(sb_tick) : 4;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmitter bus: tick enable, start request and data toward the
// transmitter, serial line and status back.
// Ports: i_tick, i_tx_start, i_data (to tx); o_tx, o_tx_done_tick, o_busy (from tx).
interface uart_tx_if #(
  parameter int NB_DATA = 8
);
  logic               i_tick;
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_tx_done_tick;
  logic               o_busy;

  // master: the parent that requests frames; slave: the transmitter.
  modport master (
    output i_tick, i_tx_start, i_data,
    input  o_tx, o_tx_done_tick, o_busy
  );

  modport slave (
    input  i_tick, i_tx_start, i_data,
    output o_tx, o_tx_done_tick, o_busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: serialises start, NB_DATA data bits (LSB first), optional
// parity and a stop period of SB_TICK oversample ticks.
// Latency: line goes low on the edge after i_tx_start is accepted in IDLE;
// frame lasts (1+NB_DATA+PARITY_EN)*16+SB_TICK ticks, o_tx_done_tick at the end.
// Backpressure: none; i_tx_start while busy is dropped, o_busy tells the parent.
// Ports: i_clk, i_reset (sync, active-high), bus (uart_tx_if.slave).
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA    = UART_NB_DATA,
  parameter int SB_TICK    = UART_SB_TICK,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  uart_tx_if.slave   bus
);

  localparam int TW = tick_cnt_width(SB_TICK);
  // NB_DATA is limited to 5..8, so three bits always cover the bit index.
  localparam int BW = 3;

  localparam logic [TW-1:0] BIT_TICK_LAST  = TW'(UART_OS_TICKS - 1);
  localparam logic [TW-1:0] STOP_TICK_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_CNT_LAST   = BW'(NB_DATA - 1);
  localparam logic          PAR_INV        = (PARITY_ODD != 0);
  localparam logic          PAR_ON         = (PARITY_EN != 0);

  logic [4:0]         state_q,    state_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [NB_DATA-1:0] shift_q,    shift_d;
  logic               parity_q,   parity_d;
  logic               tx_q,       tx_d;
  logic               done_q,     done_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // o_tx is registered, so every transition also loads the line value that
  // belongs to the state being entered.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (bus.i_tx_start) begin
          shift_d    = bus.i_data;
          // Parity is fixed at capture so later i_data changes cannot leak in.
          parity_d   = (^bus.i_data) ^ PAR_INV;
          tick_cnt_d = '0;
          state_d    = ST_START;
          tx_d       = 1'b0;
        end
      end

      ST_START: begin
        if (bus.i_tick) begin
          if (tick_cnt_q == BIT_TICK_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = ST_DATA;
            tx_d       = shift_q[0];
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (bus.i_tick) begin
          if (tick_cnt_q == BIT_TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {1'b0, shift_q[NB_DATA-1:1]};
            if (bit_cnt_q == BIT_CNT_LAST) begin
              if (PAR_ON) begin
                state_d = ST_PARITY;
                tx_d    = parity_q;
              end else begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              // Next bit is the one about to become the LSB.
              tx_d      = shift_q[1];
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (bus.i_tick) begin
          if (tick_cnt_q == BIT_TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = ST_STOP;
            tx_d       = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (bus.i_tick) begin
          if (tick_cnt_q == STOP_TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            tx_d       = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        // Corrupted one-hot vector: return to a clean idle line.
        state_d    = ST_IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        shift_d    = '0;
        parity_d   = 1'b0;
        tx_d       = 1'b1;
      end
    endcase
  end

  assign bus.o_tx           = tx_q;
  assign bus.o_tx_done_tick = done_q;
  assign bus.o_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four configurations driven by one shared
// stimulus stream (default, even parity, odd parity, two stop bits), each
// compared every clock against a frame-level reference model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic [7:0] data;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int tick_per   = 4;
  int tick_mode  = 0;   // 0 periodic, 1 random, 2 frozen
  bit last_tick  = 1'b0;
  int tk         = 0;
  bit tk_en      = 1'b0;

  always #5 clk = ~clk;

  uart_tx_if #(.NB_DATA(8)) if0 ();
  uart_tx_if #(.NB_DATA(8)) if1 ();
  uart_tx_if #(.NB_DATA(8)) if2 ();
  uart_tx_if #(.NB_DATA(8)) if3 ();

  assign if0.i_tick = tick; assign if0.i_tx_start = start; assign if0.i_data = data;
  assign if1.i_tick = tick; assign if1.i_tx_start = start; assign if1.i_data = data;
  assign if2.i_tick = tick; assign if2.i_tx_start = start; assign if2.i_data = data;
  assign if3.i_tick = tick; assign if3.i_tx_start = start; assign if3.i_data = data;

  uart_tx u0 (.i_clk(clk), .i_reset(rst), .bus(if0));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.i_clk(clk), .i_reset(rst), .bus(if1));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.i_clk(clk), .i_reset(rst), .bus(if2));
  uart_tx #(.SB_TICK(32)) u3 (.i_clk(clk), .i_reset(rst), .bus(if3));

  logic [3:0] dtx, dbusy, ddone;
  assign dtx   = {if3.o_tx, if2.o_tx, if1.o_tx, if0.o_tx};
  assign dbusy = {if3.o_busy, if2.o_busy, if1.o_busy, if0.o_busy};
  assign ddone = {if3.o_tx_done_tick, if2.o_tx_done_tick, if1.o_tx_done_tick, if0.o_tx_done_tick};

  // Per-configuration frame shape: bits before the stop period, stop ticks, parity.
  int nbits_c [4] = '{9, 10, 10, 9};
  int sb_c    [4] = '{16, 16, 16, 32};
  bit par_c   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit odd_c   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  // Reference model: a frame is a list of bits, position counts ticks.
  bit         m_act  [4];
  int         m_pos  [4];
  logic [9:0] m_frame[4];
  bit         m_done [4];

  function automatic int total_ticks(input int k);
    return nbits_c[k] * 16 + sb_c[k];
  endfunction

  function automatic logic exp_tx(input int k);
    int seg;
    if (!m_act[k]) return 1'b1;
    seg = m_pos[k] / 16;
    if (seg < nbits_c[k]) return m_frame[k][seg];
    return 1'b1;
  endfunction

  function automatic bit any_active();
    return m_act[0] | m_act[1] | m_act[2] | m_act[3];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_act[k] = 1'b0; m_pos[k] = 0; m_done[k] = 1'b0;
      end else begin
        m_done[k] = 1'b0;
        if (!m_act[k]) begin
          if (start) begin
            m_act[k] = 1'b1;
            m_pos[k] = 0;
            m_frame[k] = '1;
            m_frame[k][0] = 1'b0;
            for (int b = 0; b < 8; b++) m_frame[k][1+b] = data[b];
            if (par_c[k]) m_frame[k][9] = (^data) ^ odd_c[k];
          end
        end else if (tick) begin
          m_pos[k]++;
          if (m_pos[k] == total_ticks(k)) begin
            m_act[k] = 1'b0; m_pos[k] = 0; m_done[k] = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: choose tick, advance model, clock DUT, compare #1 later.
  task automatic step();
    case (tick_mode)
      0:       tick = ((cyc % tick_per) == 0);
      1:       tick = (($urandom % 3) == 0);
      default: tick = 1'b0;
    endcase
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    last_tick = tick;
    if (tk_en && tick) tk++;
    for (int k = 0; k < 4; k++)
      chk($sformatf("u%0d tx/busy/done", k),
          {dtx[k], dbusy[k], ddone[k]},
          {exp_tx(k), m_act[k], m_done[k]});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (any_active() && n < budget) begin
      step();
      n++;
    end
    if (any_active()) chk("wait_idle timeout", 1, 0);
  endtask

  task automatic start_frame(input logic [7:0] d);
    data  = d;
    start = 1'b1;
    step();
    start = 1'b0;
    tk    = 0;
    tk_en = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         tper;
    logic       par_even;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0] got;
    logic       p1, p2;
    int         dtk [4];
    int         n, bi, dcnt;

    tbl[0] = '{8'hA5, 4, 1'b0};
    tbl[1] = '{8'h3C, 1, 1'b0};
    tbl[2] = '{8'h07, 2, 1'b1};
    tbl[3] = '{8'hFF, 3, 1'b0};
    tbl[4] = '{8'h00, 1, 1'b0};
    tbl[5] = '{8'h01, 4, 1'b1};

    rst = 1'b1; start = 1'b0; data = 8'h00; tick = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("reset tx", dtx[0], 1);
    chk("reset busy", dbusy[0], 0);
    chk("reset done", ddone[0], 0);
    rst = 1'b0;
    step();

    // Frames from the table; i_data scrambled every clock once accepted.
    for (int i = 0; i < 6; i++) begin
      wait_idle(2000);
      tick_mode = 0;
      tick_per  = tbl[i].tper;
      got = '0; p1 = 1'bx; p2 = 1'bx;
      for (int k = 0; k < 4; k++) dtk[k] = -1;
      start_frame(tbl[i].data);
      n = 0;
      while (n < 200 * tick_per + 50 && (dtk[0] < 0 || dtk[1] < 0 || dtk[2] < 0 || dtk[3] < 0)) begin
        data = 8'($urandom);
        step();
        n++;
        if (last_tick && (tk % 16) == 8) begin
          bi = tk / 16;
          if (bi >= 1 && bi <= 8) got[bi-1] = dtx[0];
          if (bi == 9) begin p1 = dtx[1]; p2 = dtx[2]; end
        end
        for (int k = 0; k < 4; k++) if (ddone[k] && dtk[k] < 0) dtk[k] = tk;
      end
      tk_en = 1'b0;
      chk($sformatf("vec%0d byte", i), got, tbl[i].data);
      chk($sformatf("vec%0d even parity", i), p1, tbl[i].par_even);
      chk($sformatf("vec%0d odd parity", i), p2, !tbl[i].par_even);
      for (int k = 0; k < 4; k++)
        chk($sformatf("vec%0d u%0d done tick", i, k), dtk[k], total_ticks(k));
    end

    // Start held high: second frame begins on the edge after the done pulse.
    wait_idle(2000);
    tick_per = 4;
    data  = 8'h3C;
    start = 1'b1;
    n = 0;
    while (!ddone[0] && n < 1000) begin step(); n++; end
    chk("held start first done", ddone[0], 1);
    step();
    chk("back-to-back busy", dbusy[0], 1);
    chk("back-to-back start bit", dtx[0], 0);
    start = 1'b0;
    wait_idle(2000);

    // Reset in the middle of data bit 4.
    tick_per = 2;
    start_frame(8'hA5);
    n = 0;
    while (tk < 84 && n < 1000) begin step(); n++; end
    chk("reached data bit 4", tk, 84);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tk_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort u%0d tx", k), dtx[k], 1);
      chk($sformatf("abort u%0d busy", k), dbusy[k], 0);
    end
    dcnt = 0;
    for (int i = 0; i < 400; i++) begin step(); dcnt += int'(ddone[0]); end
    chk("no done after abort", dcnt, 0);
    start_frame(8'h5A);
    wait_idle(2000);

    // Tick frozen for 100 clocks inside START.
    tick_per = 1;
    start_frame(8'hC3);
    n = 0;
    while (tk < 5 && n < 100) begin step(); n++; end
    tick_mode = 2;
    for (int i = 0; i < 100; i++) step();
    chk("frozen tx", dtx[0], 0);
    chk("frozen busy", dbusy[0], 1);
    tick_mode = 0;
    tk_en = 1'b0;
    wait_idle(2000);

    // Random traffic with random ticks and sporadic resets.
    tick_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      start = (($urandom % 8) == 0);
      data  = 8'($urandom);
      rst   = (($urandom % 500) == 0);
      step();
    end
    start = 1'b0;
    rst   = 1'b0;
    wait_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
